// File: rtl/matrix_pkg.sv
// Shared definitions for the sequential matrix engine: mode codes, FSM
// state encoding and the MSB-first element packing helper.
package matrix_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_TRN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  // LSB position of element (r,c) in a flattened n x n matrix of w-bit
  // elements; (0,0) lives in the most significant slot.
  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (n * n - 1 - (r * n + c)) * w;
  endfunction

endpackage

// File: rtl/matrix_alu_seq_mac.sv
// Multiply-accumulate unit: one W x W product per cycle added to a wide
// accumulator that cannot wrap for an N-term dot product.
module matrix_mac #(
  parameter int W  = 16,
  parameter int AW = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         acc_en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum_lo,
  output logic         sum_ovf
);

  localparam logic [AW-1:0] LIMIT = {{(AW-1){1'b0}}, 1'b1} << W;

  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [2*W-1:0] prod;

  assign prod    = {{W{1'b0}}, x} * {{W{1'b0}}, y};
  assign sum     = acc + {{(AW-2*W){1'b0}}, prod};
  assign sum_lo  = sum[W-1:0];
  assign sum_ovf = (sum >= LIMIT);

  // Accumulator: clear wins over accumulate so the final term of a dot
  // product can be consumed and the register emptied in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential matrix engine: add, reverse subtract, multiply and transpose
// on N x N unsigned W-bit matrices, one adder / one MAC time-multiplexed.
module matrix_alu_seq
  import matrix_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [N*N*W-1:0] a,
  input  logic [N*N*W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] result,
  output logic             ovf
);

  localparam int CW = $clog2(N);
  localparam int AW = 2 * W + $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t           state, next_state;
  logic [N*N*W-1:0] a_q, b_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    row, col, k;
  logic [W-1:0]     a_elem, b_elem, elem_val, mac_sum;
  logic [W:0]       arith;
  logic             elem_ovf, elem_write, elem_last, accept;
  logic             mac_en, mac_clear, mac_ovf;

  assign accept    = (state == ST_IDLE) && in_valid;
  assign elem_last = elem_write && (row == LAST_IDX) && (col == LAST_IDX);

  matrix_mac #(.W(W), .AW(AW)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .acc_en (mac_en),
    .x      (a_elem),
    .y      (b_elem),
    .sum_lo (mac_sum),
    .sum_ovf(mac_ovf)
  );

  // Next-state logic: a result is only ever left through out_ready.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (in_valid) next_state = ST_COMPUTE; else next_state = ST_IDLE;
      ST_COMPUTE: if (elem_last) next_state = ST_DONE; else next_state = ST_COMPUTE;
      ST_DONE:    if (out_ready) next_state = ST_IDLE; else next_state = ST_DONE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Element datapath: selects operands for the current counters and forms
  // the value to write plus its overflow flag.
  always_comb begin
    a_elem     = '0;
    b_elem     = '0;
    arith      = '0;
    elem_val   = '0;
    elem_ovf   = 1'b0;
    elem_write = 1'b0;
    mac_en     = 1'b0;
    mac_clear  = accept;
    if (state == ST_COMPUTE) begin
      case (mode_q)
        MODE_ADD: begin
          a_elem     = a_q[elem_lsb(int'(row), int'(col), N, W) +: W];
          b_elem     = b_q[elem_lsb(int'(row), int'(col), N, W) +: W];
          arith      = {1'b0, a_elem} + {1'b0, b_elem};
          elem_val   = arith[W-1:0];
          elem_ovf   = arith[W];
          elem_write = 1'b1;
        end
        MODE_SUB: begin
          a_elem     = a_q[elem_lsb(int'(row), int'(col), N, W) +: W];
          b_elem     = b_q[elem_lsb(int'(row), int'(col), N, W) +: W];
          // Top bit of the (W+1)-bit difference is the borrow.
          arith      = {1'b0, b_elem} - {1'b0, a_elem};
          elem_val   = arith[W-1:0];
          elem_ovf   = arith[W];
          elem_write = 1'b1;
        end
        MODE_TRN: begin
          a_elem     = a_q[elem_lsb(int'(col), int'(row), N, W) +: W];
          elem_val   = a_elem;
          elem_write = 1'b1;
        end
        MODE_MUL: begin
          a_elem = a_q[elem_lsb(int'(row), int'(k), N, W) +: W];
          b_elem = b_q[elem_lsb(int'(k), int'(col), N, W) +: W];
          mac_en = 1'b1;
          if (k == LAST_IDX) begin
            elem_val   = mac_sum;
            elem_ovf   = mac_ovf;
            elem_write = 1'b1;
            mac_clear  = 1'b1;
          end else begin
            elem_write = 1'b0;
          end
        end
        default: elem_write = 1'b0;
      endcase
    end else begin
      elem_write = 1'b0;
    end
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == ST_IDLE);
      out_valid <= (next_state == ST_DONE);
    end
  end

  // Operand capture, counters, result and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_ADD;
      row    <= '0;
      col    <= '0;
      k      <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      row    <= '0;
      col    <= '0;
      k      <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else if (state == ST_COMPUTE) begin
      if (elem_write) begin
        result[elem_lsb(int'(row), int'(col), N, W) +: W] <= elem_val;
        ovf <= ovf | elem_ovf;
      end else begin
        ovf <= ovf;
      end
      if ((mode_q == MODE_MUL) && (k != LAST_IDX)) begin
        k <= k + CW'(1);
      end else begin
        k <= '0;
        if (col == LAST_IDX) begin
          col <= '0;
          if (row == LAST_IDX) row <= '0; else row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end else begin
      ovf <= ovf;
    end
  end

endmodule

// File: doc/matrix_alu_seq.md
# matrix_alu_seq

Sequential, parametrised matrix arithmetic engine: the next generation of the team's combinational matrix add/subtract block. It adds matrix multiply and transpose modes, overflow reporting, and valid/ready handshakes on both sides. It time-multiplexes one adder and one multiply-accumulate (MAC) unit across all elements. It sits between an operand-loading front end and a result consumer on the accelerator datapath.

## Interface
- `N`, default 8: matrix dimension (N×N); N ≥ 2.
- `W`, default 16: element width in bits, unsigned.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand set offered.
- `in_ready`  out  1: engine can accept operands.
- `mode`  in  2: operation, sampled on accept. 00 = A+B, 01 = B−A, 10 = A×B, 11 = transpose(A).
- `a`, `b`  in  N·N·W: flattened operands. Element (r,c) occupies bits [(N·N−1−(r·N+c))·W +: W], so (0,0) is in the MSBs.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes result.
- `result`  out  N·N·W: flattened result, same packing as the operands.
- `ovf`  out  1: set if any element of the current result overflowed W bits.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` the engine registers `a`, `b` and `mode`, clears the row/col/k counters, the accumulator, `result` and `ovf`, then goes to COMPUTE.
- COMPUTE (`in_ready` = 0):
  - Modes 00, 01, 11 process one element per cycle in row-major order, (0,0) first.
  - Add: sum mod 2^W; carry-out sets `ovf`.
  - Sub: B−A mod 2^W; borrow (A>B) sets `ovf`.
  - Transpose: result(r,c) = A(c,r); `ovf` stays 0.
  - Mode 10, each cycle: acc += A(r,k)·B(k,c), then k increments.
    - On k = N−1 the element receives the low W bits of the final sum, acc clears and the col/row counters advance.
    - `ovf` sets if the full sum ≥ 2^W.
    - Accumulator width is 2W+clog2(N) bits and never wraps internally.
  - The cycle that writes the last element (N−1,N−1) moves the engine to DONE.
- DONE:
  - `out_valid` = 1; `result` and `ovf` are held stable.
  - When `out_ready` = 1, go to IDLE.
  - `result` keeps its value in IDLE until the next accept; only `out_valid` drops.
- `ovf` is sticky across the elements of one operation and clears on the next accept.
- `in_valid` outside IDLE is ignored, and operand changes do not affect the running operation.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` all zeros, `ovf` 0, counters and accumulator 0.
- Reset asserted mid-COMPUTE or in DONE aborts immediately to the reset values; the pending result is lost.
- Latency L counts rising edges from the accepting edge to the edge after which `out_valid` = 1:
  - L = N·N for modes 00, 01, 11.
  - L = N·N·N for mode 10.
  - Defaults: 64 and 512.
- Throughput: one operation per L+2 cycles minimum (accept edge, L compute edges, one DONE edge with `out_ready` high). No back-to-back accept in DONE.
- `out_ready` held high before DONE: the result is consumed on the first DONE cycle.
- `in_valid` and `out_ready` both high in DONE: the result is consumed and the new operands are not accepted until IDLE.

## Structure
- Shared package `matrix_pkg` holds:
  - mode constants: MODE_ADD, MODE_SUB, MODE_MUL, MODE_TRN;
  - state encoding;
  - an element index/offset helper function for the MSB-first packing.
- One sub-module, `matrix_mac`: W×W multiplier plus accumulator with clear, accumulate-enable and an overflow compare against 2^W.
- Everything else (FSM, counters, operand and result registers, the add/sub path) lives in the top level.

## Test plan
- N=2, W=8, mode 00, A=[1,2;3,4], B=[10,20;30,40] -> result [11,22;33,44], `ovf` 0, `out_valid` rises exactly 4 edges after accept.
- N=2, W=8, mode 01, A=[5,0;0,0], B=[3,0;0,0] -> result(0,0)=0xFE, `ovf` 1, all other elements 0.
- N=2, W=8, mode 10, A=[1,2;3,4], B=[5,6;7,8] -> [19,22;43,50], `ovf` 0, latency 8; then A=B=all 16 -> all elements 0x00, `ovf` 1.
- N=8, W=16, mode 11 with A(r,c)=16·r+c -> result(r,c)=16·c+r, latency 64; `out_ready` held low 10 cycles keeps `result` stable and `in_ready` 0.
- `rst` pulsed at compute cycle 30 of a default-size mode 10 op -> all outputs at reset values next sample; a fresh mode 00 op afterwards completes correctly.
- `in_valid` toggling with new operands during COMPUTE -> ignored; the result matches the originally accepted operands.
